// File: rtl/toggle_counter.sv
// Multi-mode register: hold, per-bit T flip-flop toggle, modulo up/down count, clamped load.
// Define TOGGLE_COUNTER_SAT_EN to make count mode saturate instead of wrap (wrap tied low).
module toggle_counter #(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 2**WIDTH-1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t_in,
    input  logic             up_dn,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] nq,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ZERO  = '0;
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    localparam logic [1:0] MODE_HOLD   = 2'b00;
    localparam logic [1:0] MODE_TOGGLE = 2'b01;
    localparam logic [1:0] MODE_COUNT  = 2'b10;
    localparam logic [1:0] MODE_LOAD   = 2'b11;

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] cnt_next;
    logic             cnt_wrap;

`ifdef TOGGLE_COUNTER_SAT_EN
    // Out-of-range values are pulled back to the ceiling in either direction.
    always_comb begin
        cnt_next = q_q;
        cnt_wrap = 1'b0;
        if (up_dn) begin
            if (q_q < MAX_V) cnt_next = q_q + ONE;
            else             cnt_next = MAX_V;
        end else begin
            if (q_q > MAX_V)      cnt_next = MAX_V;
            else if (q_q != ZERO) cnt_next = q_q - ONE;
            else                  cnt_next = ZERO;
        end
    end
`else
    // Wrap flags only true modulus rollover, never out-of-range recovery.
    always_comb begin
        cnt_next = q_q;
        cnt_wrap = 1'b0;
        if (up_dn) begin
            if (q_q < MAX_V) begin
                cnt_next = q_q + ONE;
            end else begin
                cnt_next = ZERO;
                cnt_wrap = (q_q == MAX_V);
            end
        end else begin
            if (q_q == ZERO) begin
                cnt_next = MAX_V;
                cnt_wrap = 1'b1;
            end else if (q_q > MAX_V) begin
                cnt_next = MAX_V;
            end else begin
                cnt_next = q_q - ONE;
            end
        end
    end
`endif

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (en) begin
            unique case (mode)
                MODE_HOLD:   q_d = q_q;
                MODE_TOGGLE: q_d = q_q ^ t_in;
                MODE_COUNT: begin
                    q_d    = cnt_next;
                    wrap_d = cnt_wrap;
                end
                MODE_LOAD:   q_d = (load_val > MAX_V) ? MAX_V : load_val;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign q    = q_q;
    assign nq   = ~q_q;
    assign wrap = wrap_q;
    assign tc   = up_dn ? (q_q == MAX_V) : (q_q == ZERO);

endmodule

// File: doc/toggle_counter.md
TOGGLE_COUNTER -- requirements
Module: toggle_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning register width in bits (legal 1..32).
REQ-002 SHALL have parameter MAX_COUNT, default 2**WIDTH-1, meaning the counting modulus ceiling (legal 1..2**WIDTH-1).
REQ-003 SHALL have port clk, input, 1, the clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port en, input, 1, global enable; when low, state holds regardless of mode.
REQ-006 SHALL have port mode, input, 2, operation select: 00 hold, 01 toggle, 10 count, 11 load.
REQ-007 SHALL have port t_in, input, WIDTH, per-bit toggle enables used in toggle mode.
REQ-008 SHALL have port up_dn, input, 1, count direction: 1 up, 0 down.
REQ-009 SHALL have port load_val, input, WIDTH, value captured in load mode.
REQ-010 SHALL have port q, output, WIDTH, registered state.
REQ-011 SHALL have port nq, output, WIDTH, bitwise inverse of q, combinational.
REQ-012 SHALL have port tc, output, 1, terminal count: combinational, high when q==MAX_COUNT with up_dn=1 or q==0 with up_dn=0.
REQ-013 SHALL have port wrap, output, 1, registered one-cycle pulse flagging a count-mode wrap.

Function
REQ-014 SHALL update q only on a rising clk edge with en=1 and reset=0; en=0 holds q and forces wrap to 0 next cycle.
REQ-015 SHALL, in mode 00, hold q.
REQ-016 SHALL, in mode 01, set q <= q XOR t_in, each bit behaving as an independent T flip-flop; no modulus applied; wrap <= 0.
REQ-017 SHALL, in mode 10 with up_dn=1, set q <= q+1 when q<MAX_COUNT, q <= 0 when q>=MAX_COUNT.
REQ-018 SHALL, in mode 10 with up_dn=0, set q <= q-1 when 0<q<=MAX_COUNT, q <= MAX_COUNT when q==0 or q>MAX_COUNT.
REQ-019 SHALL assert wrap for exactly the cycle after a count-mode transition MAX_COUNT->0 (up) or 0->MAX_COUNT (down); not for out-of-range recovery (q>MAX_COUNT).
REQ-020 SHALL, in mode 11, set q <= min(load_val, MAX_COUNT); wrap <= 0.
REQ-021 SHALL give one-cycle latency from input sampling to q; nq and tc follow q combinationally in the same cycle.
REQ-022 SHALL let up_dn change on any cycle; the value sampled at the edge decides direction.

Reset
REQ-023 SHALL, while reset=1, force q=0, nq=all ones, wrap=0 immediately, independent of clk.
REQ-024 SHALL, on reset assertion mid-count or mid-load, abandon the operation; the first edge after deassertion operates from q=0.
REQ-025 SHALL give tc=1 during reset iff up_dn=0.

Configuration
REQ-026 SHALL support macro TOGGLE_COUNTER_SAT_EN: when defined, count mode saturates (up stops at MAX_COUNT, down stops at 0, out-of-range up goes to MAX_COUNT) and wrap is tied 0; when undefined, REQ-017..REQ-019 wrap behaviour applies. Ports identical in both builds.

Verification
REQ-027 SHALL cover: WIDTH=4, MAX_COUNT=9, mode=10, up_dn=1 from reset, 10 edges -> q 1..9 then 0; wrap=1 only the cycle after q=0 appears.
REQ-028 SHALL cover: q=0, mode=10, up_dn=0, 1 edge -> q=9, wrap pulse, tc=1 while q=0 before edge.
REQ-029 SHALL cover: q=4'b0101, mode=01, t_in=4'b1111 -> q=4'b1010, nq=4'b0101; t_in=4'b0000 -> q unchanged.
REQ-030 SHALL cover: mode=11, load_val=14, MAX_COUNT=9 -> q=9; then en=0 with mode=10 for 3 edges -> q stays 9.
REQ-031 SHALL cover: reset pulsed between clk edges during count at q=6 -> q=0 immediately, wrap=0, next edge q=1.
REQ-032 SHALL cover: TOGGLE_COUNTER_SAT_EN defined, q=9, mode=10, up_dn=1, 3 edges -> q=9, wrap=0 throughout.
